// File: rtl/predicate_pkg.sv
// Shared sizing for the per-lane predicate register file.
package predicate_pkg;
  localparam int NUM_LANES = 8;
  localparam int NUM_WARPS = 8;
  localparam int NUM_REGS  = 64;
  localparam int WARP_W    = $clog2(NUM_WARPS);
  localparam int ADDR_W    = $clog2(NUM_REGS);

  typedef struct packed {
    logic [NUM_LANES-1:0] en;
    logic [ADDR_W-1:0]    addr;
  } rd_port_t;

  typedef struct packed {
    logic [NUM_LANES-1:0] we;
    logic [ADDR_W-1:0]    addr;
    logic [NUM_LANES-1:0] data;
  } wr_port_t;
endpackage

// File: rtl/predicate_lane_bank.sv
// One lane's predicate storage: NUM_WARPS x NUM_REGS bits, 1 write and 2 async reads.
module predicate_lane_bank
  import predicate_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WARP_W-1:0] warp_selector,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic              re_0,
  input  logic [ADDR_W-1:0] raddr_0,
  input  logic              re_1,
  input  logic [ADDR_W-1:0] raddr_1,
  output logic              rdata_0,
  output logic              rdata_1
);
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst_n)
      mem <= '0;
    else if (we)
      mem[warp_selector][waddr] <= wdata;
  end

  // No write-through: reads see the stored value until the capturing edge.
  assign rdata_0 = re_0 & mem[warp_selector][raddr_0];
  assign rdata_1 = re_1 & mem[warp_selector][raddr_1];
endmodule

// File: rtl/predicate_reg_block.sv
// Predicate register file top: fans scalar per-lane ports into the lane bank array.
module predicate_reg_block
  import predicate_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WARP_W-1:0]    warp_selector,
  input  logic [NUM_LANES-1:0] write_en,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic                 wdata_0,
  input  logic                 wdata_1,
  input  logic                 wdata_2,
  input  logic                 wdata_3,
  input  logic                 wdata_4,
  input  logic                 wdata_5,
  input  logic                 wdata_6,
  input  logic                 wdata_7,
  input  logic [NUM_LANES-1:0] read_en_0,
  input  logic [ADDR_W-1:0]    raddr_0,
  input  logic [NUM_LANES-1:0] read_en_1,
  input  logic [ADDR_W-1:0]    raddr_1,
  output logic                 rdata_0_0,
  output logic                 rdata_0_1,
  output logic                 rdata_0_2,
  output logic                 rdata_0_3,
  output logic                 rdata_0_4,
  output logic                 rdata_0_5,
  output logic                 rdata_0_6,
  output logic                 rdata_0_7,
  output logic                 rdata_1_0,
  output logic                 rdata_1_1,
  output logic                 rdata_1_2,
  output logic                 rdata_1_3,
  output logic                 rdata_1_4,
  output logic                 rdata_1_5,
  output logic                 rdata_1_6,
  output logic                 rdata_1_7
);
  wr_port_t             wr;
  rd_port_t             rd_0, rd_1;
  logic [NUM_LANES-1:0] rdata_0_v, rdata_1_v;

  assign wr   = '{we: write_en, addr: waddr,
                  data: {wdata_7, wdata_6, wdata_5, wdata_4,
                         wdata_3, wdata_2, wdata_1, wdata_0}};
  assign rd_0 = '{en: read_en_0, addr: raddr_0};
  assign rd_1 = '{en: read_en_1, addr: raddr_1};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    predicate_lane_bank u_bank (
      .clk           (clk),
      .rst_n         (rst_n),
      .warp_selector (warp_selector),
      .we            (wr.we[l]),
      .waddr         (wr.addr),
      .wdata         (wr.data[l]),
      .re_0          (rd_0.en[l]),
      .raddr_0       (rd_0.addr),
      .re_1          (rd_1.en[l]),
      .raddr_1       (rd_1.addr),
      .rdata_0       (rdata_0_v[l]),
      .rdata_1       (rdata_1_v[l])
    );
  end

  assign {rdata_0_7, rdata_0_6, rdata_0_5, rdata_0_4,
          rdata_0_3, rdata_0_2, rdata_0_1, rdata_0_0} = rdata_0_v;
  assign {rdata_1_7, rdata_1_6, rdata_1_5, rdata_1_4,
          rdata_1_3, rdata_1_2, rdata_1_1, rdata_1_0} = rdata_1_v;
endmodule

// File: tb/tb_predicate_reg_block.sv
// Directed + randomized bench for predicate_reg_block against an array reference model.
module tb_predicate_reg_block;
  logic       clk = 0;
  logic       rst_n;
  logic [2:0] ws;
  logic [7:0] we, wd, re0, re1;
  logic [5:0] wa, ra0, ra1;
  wire  [7:0] rd0, rd1;

  bit ref_mem [8][8][64];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  predicate_reg_block dut (
    .clk(clk), .rst_n(rst_n), .warp_selector(ws), .write_en(we), .waddr(wa),
    .wdata_0(wd[0]), .wdata_1(wd[1]), .wdata_2(wd[2]), .wdata_3(wd[3]),
    .wdata_4(wd[4]), .wdata_5(wd[5]), .wdata_6(wd[6]), .wdata_7(wd[7]),
    .read_en_0(re0), .raddr_0(ra0), .read_en_1(re1), .raddr_1(ra1),
    .rdata_0_0(rd0[0]), .rdata_0_1(rd0[1]), .rdata_0_2(rd0[2]), .rdata_0_3(rd0[3]),
    .rdata_0_4(rd0[4]), .rdata_0_5(rd0[5]), .rdata_0_6(rd0[6]), .rdata_0_7(rd0[7]),
    .rdata_1_0(rd1[0]), .rdata_1_1(rd1[1]), .rdata_1_2(rd1[2]), .rdata_1_3(rd1[3]),
    .rdata_1_4(rd1[4]), .rdata_1_5(rd1[5]), .rdata_1_6(rd1[6]), .rdata_1_7(rd1[7])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] en, input logic [5:0] a);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[i] = en[i] & ref_mem[i][ws][a];
    return e;
  endfunction

  // Advance one edge and apply the same edge to the model, then settle.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      for (int l = 0; l < 8; l++)
        for (int w = 0; w < 8; w++)
          for (int r = 0; r < 64; r++) ref_mem[l][w][r] = 0;
    end else begin
      for (int l = 0; l < 8; l++)
        if (we[l]) ref_mem[l][ws][wa] = wd[l];
    end
    #1;
  endtask

  task automatic set_rd(input logic [7:0] e0, input logic [5:0] a0,
                        input logic [7:0] e1, input logic [5:0] a1);
    re0 = e0; ra0 = a0; re1 = e1; ra1 = a1;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_p0"}, rd0, exp_rd(re0, ra0));
    chk({tag, "_p1"}, rd1, exp_rd(re1, ra1));
  endtask

  initial begin
    rst_n = 0; ws = 0; we = 0; wd = 0; wa = 0;
    re0 = 0; re1 = 0; ra0 = 0; ra1 = 0;
    #1;
    chk("rst_out0", rd0, 8'h00);
    chk("rst_out1", rd1, 8'h00);
    step();
    rst_n = 1;

    // Reset clear
    for (int a = 0; a < 64; a++) begin
      set_rd(8'hFF, 6'(a), 8'hFF, 6'(a));
      chk("rst_clr_p0", rd0, 8'h00);
      chk("rst_clr_p1", rd1, 8'h00);
    end

    // Lane mask
    ws = 2; we = 8'h5A; wa = 6'h15; wd = 8'hFF;
    step();
    we = 0;
    set_rd(8'hFF, 6'h15, 8'hFF, 6'h15);
    chk("mask_p0", rd0, 8'h5A);
    chk("mask_p1", rd1, 8'h5A);

    // Warp isolation
    ws = 7; we = 8'hFF; wa = 6'h3F; wd = 8'hFF;
    step();
    we = 0;
    for (int w = 0; w < 8; w++) begin
      ws = 3'(w);
      set_rd(8'hFF, 6'h3F, 8'hFF, 6'h3F);
      chk("warp_iso_p0", rd0, (w == 7) ? 8'hFF : 8'h00);
      chk("warp_iso_p1", rd1, (w == 7) ? 8'hFF : 8'h00);
    end

    // Read enable gating
    ws = 0; we = 8'hFF; wa = 0; wd = 8'hFF;
    step();
    we = 0;
    set_rd(8'h0F, 6'h00, 8'hF0, 6'h00);
    chk("gate_p0", rd0, 8'h0F);
    chk("gate_p1", rd1, 8'hF0);

    // Read-during-write: old value before the edge, new value after
    ws = 0; we = 8'hFF; wa = 5; wd = 8'hFF;
    set_rd(8'hFF, 6'd5, 8'hFF, 6'd5);
    chk("rdw_before", rd0, 8'h00);
    step();
    we = 0;
    chk("rdw_after_p0", rd0, 8'hFF);
    chk("rdw_after_p1", rd1, 8'hFF);

    // Mid-run reset discards the same-edge write
    rst_n = 0; we = 8'hFF; wa = 9; wd = 8'hFF;
    step();
    rst_n = 1; we = 0;
    set_rd(8'hFF, 6'd9, 8'hFF, 6'd5);
    chk("midrst_a9", rd0, 8'h00);
    chk("midrst_a5", rd1, 8'h00);

    // Full sweep
    for (int w = 0; w < 8; w++) begin
      for (int a = 0; a < 64; a++) begin
        ws = 3'(w); we = 8'hFF; wa = 6'(a); wd = 8'hFF;
        set_rd(8'h00, 6'h00, 8'h00, 6'h00);
        step();
        we = 0;
        set_rd(8'hFF, 6'(a), 8'h00, 6'(a));
        chk("sweep_p0", rd0, 8'hFF);
        step();
        set_rd(8'h00, 6'(a), 8'hFF, 6'(a));
        chk("sweep_p1", rd1, 8'hFF);
        step();
        set_rd(8'hFF, 6'(a), 8'hFF, 6'(a));
        chk("sweep_both0", rd0, 8'hFF);
        chk("sweep_both1", rd1, 8'hFF);
        step();
      end
    end

    // Randomized traffic; small address window forces collisions and RDW cases
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      ws = 3'($urandom_range(0, 7));
      we = 8'($urandom);
      wd = 8'($urandom);
      wa = 6'($urandom_range(0, 7));
      set_rd(8'($urandom), 6'($urandom_range(0, 7)),
             8'($urandom), ($urandom_range(0, 3) == 0) ? ra0 : 6'($urandom_range(0, 7)));
      chk_model("rand");
      step();
      chk_model("rand_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/predicate_reg_block.md
# predicate_reg_block

Per-lane predicate register file for an 8-lane, 8-warp SIMT core. Holds 64 one-bit predicate registers per lane per warp, with one write port and two read ports shared by all lanes. The currently active warp is selected by `warp_selector`. Sits beside the general register file, feeding predicate operands to issue and accepting predicate results from writeback.

## Interface
Parameters:
- NUM_LANES, 8, lanes; one storage bank and one wdata/rdata set per lane.
- NUM_WARPS, 8, warps; `warp_selector` width is log2(NUM_WARPS) = 3.
- NUM_REGS, 64, predicate registers per lane per warp; address width is log2(NUM_REGS) = 6.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- warp_selector  in  3  active warp for both reads and writes.
- write_en  in  8  per-lane write enable; bit i targets lane i.
- waddr  in  6  write register address, common to all lanes.
- wdata_0 .. wdata_7  in  1 each  write data for lanes 0..7.
- read_en_0  in  8  per-lane enable for read port 0.
- raddr_0  in  6  read port 0 address, common to all lanes.
- read_en_1  in  8  per-lane enable for read port 1.
- raddr_1  in  6  read port 1 address, common to all lanes.
- rdata_0_0 .. rdata_0_7  out  1 each  read port 0 data for lanes 0..7.
- rdata_1_0 .. rdata_1_7  out  1 each  read port 1 data for lanes 0..7.

## Operation
- Storage: bit `mem[lane][warp][reg]`, giving 8×8×64 = 4096 bits in total.
- Write: at a rising `clk` edge with `rst_n`=1, for each lane i with `write_en[i]`=1: `mem[i][warp_selector][waddr] <= wdata_i`.
  - Lanes with `write_en[i]`=0 are unchanged.
  - Other warps are never touched.
- Read port p (p = 0 or 1), lane i, combinational:
  - `rdata_p_i = read_en_p[i] ? mem[i][warp_selector][raddr_p] : 0`.
- Ports 0 and 1 are fully independent. They may read the same or different addresses in the same cycle, with identical results for the same address.
- Reset: while `rst_n`=0 at a rising edge, every storage bit clears to 0 and all writes that cycle are ignored.
- Outputs after reset: 0 (disabled reads return 0; enabled reads return cleared storage).
- Read-during-write, same warp and address: the read returns the old value until the write edge, then the new value. There is no write-through bypass.
- Changing `warp_selector` takes effect immediately on reads and on the next write edge.
- Addresses cover exactly 0..63, so there is no out-of-range case.

## Timing
- Write latency: 1 edge. Data is readable combinationally immediately after the edge that captured it.
- Read latency: 0 cycles, a purely combinational path from `warp_selector`, `raddr_p`, `read_en_p` and storage to `rdata`.
- No handshake and no stalls; every cycle accepts one write (to any subset of lanes) plus two reads.
- Reset is synchronous. Asserting `rst_n` mid-operation clears storage at the next rising edge, and that edge's write is discarded.

## Structure
- Shared package `predicate_pkg`:
  - constants NUM_LANES, NUM_WARPS, NUM_REGS;
  - derived widths WARP_W = 3 and ADDR_W = 6.
- Sub-module `predicate_lane_bank`, instantiated once per lane via generate:
  - inputs: clk, rst_n, warp_selector, we, waddr, wdata, two read enable/address pairs;
  - outputs: two 1-bit read outputs;
  - storage: 512 bits (8 warps × 64).
- Top level only fans the scalar wdata/rdata ports in and out of the lane array.

## Test plan
- Reset clear:
  - stimulus: hold `rst_n`=0 for 1 edge, then read all 64 addresses in warp 0 on both ports with enables 8'hFF;
  - expected: every `rdata` = 0.
- Full sweep:
  - stimulus: for warps 0..7 and addresses 0..63, write 1 with `write_en`=8'hFF; next cycle read port 0; next read port 1; next read both ports at once;
  - expected: every lane returns 1 on each read.
- Lane mask:
  - stimulus: warp 2, addr 6'h15, `write_en`=8'h5A, all wdata=1;
  - expected: reading with enables 8'hFF gives lanes 1,3,4,6 = 1 and lanes 0,2,5,7 = 0.
- Warp isolation:
  - stimulus: write 1 to addr 6'h3F in warp 7 only;
  - expected: same address in warps 0..6 reads 0; warp 7 reads 1.
- Read enable gating:
  - stimulus: stored 1 at addr 0; `read_en_0`=8'h0F, `read_en_1`=8'hF0;
  - expected: port 0 lanes 0–3 = 1 and lanes 4–7 = 0; port 1 the mirror.
- Read-during-write and mid-run reset:
  - stimulus: with addr 5 holding 0, write 1 to addr 5 while also reading addr 5;
  - expected: read shows 0 before the edge and 1 after it;
  - stimulus: drop `rst_n` for one edge while writing addr 9;
  - expected: addr 9 and addr 5 both read 0.
